btn_debounce_array: RTL and testbench
=====================================

Name: btn_debounce_array

Overview:
- Parametrised multi-channel push-button conditioner. It replaces fixed 5-button, fixed-length pulse stretching with per-channel synchronisation, stable-count debouncing, press/release edge pulses, optional auto-repeat, and a stretched synchronous reset output.
- Sits between the board buttons and the game/control FSMs, clocked by the slow debounce_clk domain.

Parameters:
- NUM_CH, 5, number of independent button channels.
- SYNC_STAGES, 2, synchroniser depth per channel (>=2).
- STABLE_CYCLES, 1024, consecutive differing samples required before level_o changes (>=1).
- REPEAT_DELAY, 256, cycles of continuous hold after a press before the first auto-repeat pulse (>=1).
- REPEAT_PERIOD, 64, cycles between subsequent auto-repeat pulses (>=1).
- RST_STRETCH, 2, cycles rst_o stays high after arst_i deasserts (>=1).

Ports:
- debounce_clk  input  1  block clock.
- arst_i  input  1  reset, asynchronous, active-high.
- btn_i  input  NUM_CH  raw asynchronous button levels, 1 = pressed.
- repeat_en_i  input  NUM_CH  per-channel auto-repeat enable, synchronous to debounce_clk.
- level_o  output  NUM_CH  debounced level.
- press_o  output  NUM_CH  1-cycle pulse on debounced rise and on each auto-repeat.
- release_o  output  NUM_CH  1-cycle pulse on debounced fall.
- rst_o  output  1  stretched reset for downstream logic: async assert, sync deassert.

Behaviour:
- Reset (arst_i=1, async):
  - All sync flops, stable counters, repeat counters, level_o, press_o and release_o clear to 0.
  - Every repeat FSM goes to IDLE.
  - rst_o=1 immediately.
- rst_o:
  - RST_STRETCH-bit shift register, async-set to all-ones, shifts in 0 each edge.
  - rst_o is bit 0, so it falls on the RST_STRETCH-th edge after arst_i deasserts.
  - Channel logic uses only arst_i, not rst_o.
- Synchroniser: btn_i[c] passes through SYNC_STAGES flops; s[c] is the last stage.
- Stable counter (per channel, width $clog2(STABLE_CYCLES+1)):
  - If s != level: counter increments.
  - When the counter reaches STABLE_CYCLES-1 and s still != level on that edge, level toggles and the counter clears.
  - If s == level: counter clears, so a glitch shorter than STABLE_CYCLES samples is fully discarded.
- Latency: a btn_i change sampled at edge 1 and held produces a level_o change on edge SYNC_STAGES+STABLE_CYCLES.
- Edge pulses:
  - press_o[c]=1 for exactly the cycle following the edge where level rises.
  - release_o[c] behaves the same on fall.
  - Both are registered, and press and release are never high together on one channel.
- Auto-repeat FSM (per channel, repeat counter width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)):
  - IDLE: on a level rise, emit the press pulse, clear the counter, and go to DELAY if repeat_en_i[c]=1; otherwise stay IDLE.
  - DELAY: counter increments each cycle. On reaching REPEAT_DELAY, emit a press pulse, clear the counter and go to REPEAT.
  - REPEAT: counter increments. On reaching REPEAT_PERIOD, emit a press pulse and clear the counter.
  - DELAY/REPEAT exit: level fall or repeat_en_i[c]=0 goes to IDLE the next edge with no further repeat pulses. Release pulse still fires on the fall.
  - Re-asserting repeat_en_i while the button is held and the FSM is IDLE does nothing until the next debounced press.
  - A repeat pulse coinciding with a level fall is suppressed; release wins.
- Channels are fully independent; simultaneous activity on any subset of channels behaves as each channel alone.
- arst_i asserted mid-count or mid-repeat aborts immediately. After release, a button still held is re-detected normally and produces a fresh press after full latency.

Test Plan:
(Sim params: NUM_CH=5, SYNC_STAGES=2, STABLE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, RST_STRETCH=2.)
- Reset: pulse arst_i mid-cycle -> rst_o rises asynchronously and falls on edge 2 after deassert; all outputs 0 throughout.
- Clean press on ch0 held 40 cycles, repeat_en=0, sampled at edge 1 -> level_o[0] rises at edge 10; single press_o pulse; release after drop gives level fall at +10 edges with one release_o pulse.
- Bounce: ch1 toggles every 3 cycles for 30 cycles, then settles high -> no level_o/press_o activity during the bounce; rise exactly 10 edges after the last toggle.
- Auto-repeat: ch2 held 60 cycles with repeat_en=1 -> press pulses at level-rise cycle r, r+20, r+25, r+30, ...; after release, no more presses and one release_o.
- repeat_en_i dropped at r+22 while held -> no pulse at r+25 or later; level_o stays 1 until release.
- All 5 channels pressed on the same cycle, with arst_i asserted at 5 cycles into the stable count -> no press pulses; after reset release, all 5 rise together 10 edges later with simultaneous press pulses.

Source files
------------

// File: rtl/btn_debounce_array.sv
// rtl/btn_debounce_array.sv - multi-channel button synchroniser, debouncer, edge/auto-repeat pulser
// Each channel is independent; rst_o is a stretched copy of arst_i for downstream logic.
module btn_debounce_array #(
   parameter int NUM_CH        = 5,
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 1024,
   parameter int REPEAT_DELAY  = 256,
   parameter int REPEAT_PERIOD = 64,
   parameter int RST_STRETCH   = 2
) (
   input  logic              debounce_clk,
   input  logic              arst_i,
   input  logic [NUM_CH-1:0] btn_i,
   input  logic [NUM_CH-1:0] repeat_en_i,
   output logic [NUM_CH-1:0] level_o,
   output logic [NUM_CH-1:0] press_o,
   output logic [NUM_CH-1:0] release_o,
   output logic              rst_o
);

   localparam int SW      = $clog2(STABLE_CYCLES + 1);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW      = $clog2(RPT_MAX + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rpt_state_e;

   logic [RST_STRETCH-1:0] rst_q;

   always_ff @(posedge debounce_clk or posedge arst_i) begin
      if (arst_i) begin
         rst_q <= '1;
      end else begin
         rst_q <= rst_q >> 1;
      end
   end

   assign rst_o = rst_q[0];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SW-1:0]          scnt_q;
      logic [RW-1:0]          rcnt_q;
      logic                   level_q;
      logic                   press_q;
      logic                   release_q;
      rpt_state_e             state_q;
      logic                   s;
      logic                   flip_d;
      logic                   rise_d;
      logic                   fall_d;

      assign s      = sync_q[SYNC_STAGES-1];
      assign flip_d = (s != level_q) && (scnt_q == SW'(STABLE_CYCLES - 1));
      assign rise_d = flip_d && !level_q;
      assign fall_d = flip_d && level_q;

      // Exit checks come before the count so a repeat coinciding with a fall is dropped.
      always_ff @(posedge debounce_clk or posedge arst_i) begin
         if (arst_i) begin
            sync_q    <= '0;
            scnt_q    <= '0;
            rcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            state_q   <= IDLE;
         end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_i[c]};
            press_q   <= 1'b0;
            release_q <= fall_d;

            if (s == level_q) begin
               scnt_q <= '0;
            end else if (flip_d) begin
               scnt_q  <= '0;
               level_q <= ~level_q;
            end else begin
               scnt_q <= scnt_q + SW'(1);
            end

            case (state_q)
               IDLE: begin
                  if (rise_d) begin
                     press_q <= 1'b1;
                     rcnt_q  <= '0;
                     if (repeat_en_i[c]) begin
                        state_q <= DELAY;
                     end
                  end
               end
               DELAY: begin
                  if (fall_d || !repeat_en_i[c]) begin
                     state_q <= IDLE;
                     rcnt_q  <= '0;
                  end else if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
                     press_q <= 1'b1;
                     rcnt_q  <= '0;
                     state_q <= REPEAT;
                  end else begin
                     rcnt_q <= rcnt_q + RW'(1);
                  end
               end
               REPEAT: begin
                  if (fall_d || !repeat_en_i[c]) begin
                     state_q <= IDLE;
                     rcnt_q  <= '0;
                  end else if (rcnt_q == RW'(REPEAT_PERIOD - 1)) begin
                     press_q <= 1'b1;
                     rcnt_q  <= '0;
                  end else begin
                     rcnt_q <= rcnt_q + RW'(1);
                  end
               end
               default: begin
                  state_q <= IDLE;
                  rcnt_q  <= '0;
               end
            endcase
         end
      end

      assign level_o[c]   = level_q;
      assign press_o[c]   = press_q;
      assign release_o[c] = release_q;
   end

endmodule

// File: tb/tb_btn_debounce_array.sv
// tb/tb_btn_debounce_array.sv - randomized and directed bench for btn_debounce_array
// Reference model works on sample histories, run lengths and elapsed-hold arithmetic.
module tb_btn_debounce_array;

   localparam int NUM_CH        = 5;
   localparam int SYNC_STAGES   = 2;
   localparam int STABLE_CYCLES = 8;
   localparam int REPEAT_DELAY  = 20;
   localparam int REPEAT_PERIOD = 5;
   localparam int RST_STRETCH   = 2;

   logic              debounce_clk = 1'b0;
   logic              arst_i       = 1'b1;
   logic [NUM_CH-1:0] btn_i        = '0;
   logic [NUM_CH-1:0] repeat_en_i  = '0;
   logic [NUM_CH-1:0] level_o;
   logic [NUM_CH-1:0] press_o;
   logic [NUM_CH-1:0] release_o;
   logic              rst_o;

   btn_debounce_array #(
      .NUM_CH        (NUM_CH),
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .RST_STRETCH   (RST_STRETCH)
   ) dut (
      .debounce_clk (debounce_clk),
      .arst_i       (arst_i),
      .btn_i        (btn_i),
      .repeat_en_i  (repeat_en_i),
      .level_o      (level_o),
      .press_o      (press_o),
      .release_o    (release_o),
      .rst_o        (rst_o)
   );

   always #5 debounce_clk = ~debounce_clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [NUM_CH-1:0] bhist[$];
   logic [NUM_CH-1:0] m_lvl, m_press, m_rel, m_rep;
   int                m_run[NUM_CH];
   int                m_held[NUM_CH];
   int                m_rst_edges;
   int                pc[NUM_CH];
   int                rc[NUM_CH];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      bhist.delete();
      for (int i = 0; i < SYNC_STAGES; i++) bhist.push_back('0);
      m_lvl = '0; m_press = '0; m_rel = '0; m_rep = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_run[c]  = 0;
         m_held[c] = 0;
      end
      m_rst_edges = 0;
   endtask

   task automatic model_step(input logic [NUM_CH-1:0] b, input logic [NUM_CH-1:0] e);
      logic [NUM_CH-1:0] sv;
      bit rise, fall;
      sv = bhist.pop_front();
      bhist.push_back(b);
      for (int c = 0; c < NUM_CH; c++) begin
         rise = 0; fall = 0;
         m_press[c] = 1'b0;
         m_rel[c]   = 1'b0;
         if (sv[c] != m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] == STABLE_CYCLES) begin
               m_lvl[c] = ~m_lvl[c];
               m_run[c] = 0;
               if (m_lvl[c]) rise = 1; else fall = 1;
            end
         end else begin
            m_run[c] = 0;
         end
         if (rise) begin
            m_press[c] = 1'b1;
            m_rep[c]   = e[c];
            m_held[c]  = 0;
         end else if (m_rep[c]) begin
            if (fall || !e[c]) begin
               m_rep[c] = 1'b0;
            end else begin
               m_held[c]++;
               if (m_held[c] == REPEAT_DELAY ||
                   (m_held[c] > REPEAT_DELAY && (m_held[c] - REPEAT_DELAY) % REPEAT_PERIOD == 0))
                  m_press[c] = 1'b1;
            end
         end
         if (fall) m_rel[c] = 1'b1;
      end
      if (m_rst_edges < 1000) m_rst_edges++;
   endtask

   task automatic tick();
      logic [NUM_CH-1:0] b, e;
      b = btn_i;
      e = repeat_en_i;
      @(posedge debounce_clk);
      if (arst_i) model_reset();
      else model_step(b, e);
      #1;
      check_eq("level", 32'(level_o), 32'(m_lvl));
      check_eq("press", 32'(press_o), 32'(m_press));
      check_eq("release", 32'(release_o), 32'(m_rel));
      check_eq("rst", 32'(rst_o), 32'(arst_i || (m_rst_edges < RST_STRETCH)));
      for (int c = 0; c < NUM_CH; c++) begin
         pc[c] += int'(press_o[c]);
         rc[c] += int'(release_o[c]);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear_counts();
      for (int c = 0; c < NUM_CH; c++) begin
         pc[c] = 0;
         rc[c] = 0;
      end
   endtask

   task automatic assert_reset();
      #3;
      arst_i = 1'b1;
      model_reset();
      #1;
      check_eq("rst_async", 32'(rst_o), 32'd1);
      check_eq("level_async", 32'(level_o), 32'd0);
      check_eq("press_async", 32'(press_o), 32'd0);
      check_eq("release_async", 32'(release_o), 32'd0);
   endtask

   task automatic release_reset();
      #2;
      arst_i = 1'b0;
   endtask

   initial begin
      model_reset();
      clear_counts();
      ticks(3);
      release_reset();
      ticks(4);

      assert_reset();
      ticks(2);
      release_reset();
      ticks(4);

      clear_counts();
      btn_i[0] = 1'b1;
      ticks(40);
      btn_i[0] = 1'b0;
      ticks(20);
      check_eq("ch0_press_cnt", 32'(pc[0]), 32'd1);
      check_eq("ch0_release_cnt", 32'(rc[0]), 32'd1);

      clear_counts();
      for (int i = 0; i < 10; i++) begin
         btn_i[1] = ~btn_i[1];
         ticks(3);
      end
      btn_i[1] = 1'b1;
      ticks(9);
      check_eq("ch1_bounce_level", 32'(level_o[1]), 32'd0);
      tick();
      check_eq("ch1_rise_edge", 32'(level_o[1]), 32'd1);
      btn_i[1] = 1'b0;
      ticks(15);
      check_eq("ch1_press_cnt", 32'(pc[1]), 32'd1);

      clear_counts();
      repeat_en_i[2] = 1'b1;
      btn_i[2] = 1'b1;
      ticks(60);
      btn_i[2] = 1'b0;
      ticks(20);
      check_eq("ch2_repeat_cnt", 32'(pc[2]), 32'd9);
      check_eq("ch2_release_cnt", 32'(rc[2]), 32'd1);

      clear_counts();
      btn_i[2] = 1'b1;
      ticks(31);
      repeat_en_i[2] = 1'b0;
      ticks(29);
      check_eq("ch2_held_level", 32'(level_o[2]), 32'd1);
      btn_i[2] = 1'b0;
      ticks(20);
      check_eq("ch2_endrop_cnt", 32'(pc[2]), 32'd2);

      clear_counts();
      btn_i = '1;
      ticks(7);
      assert_reset();
      ticks(2);
      release_reset();
      check_eq("all_abort_presses", 32'(pc[0] + pc[1] + pc[2] + pc[3] + pc[4]), 32'd0);
      ticks(9);
      check_eq("all_pre_rise", 32'(level_o), 32'd0);
      tick();
      check_eq("all_rise", 32'(level_o), 32'h1f);
      check_eq("all_press", 32'(press_o), 32'h1f);
      btn_i = '0;
      ticks(15);

      repeat_en_i = '1;
      for (int i = 0; i < 800; i++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if ($urandom_range(0, 11) == 0) btn_i[c] = ~btn_i[c];
            if ($urandom_range(0, 39) == 0) repeat_en_i[c] = ~repeat_en_i[c];
         end
         if (i == 400) begin
            assert_reset();
            ticks(1);
            release_reset();
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
